rf_wb_arbiter: RTL

- Shares the single register-file write port between NUM_REQ writeback requesters: ALU, load unit and CSR/debug.
- Uses round-robin arbitration with a valid/ready handshake.
- Registers the winning write onto the register-file write port.
- Keeps a pending-write scoreboard, busy_out, so the issue stage can stall on RAW hazards against in-flight writes.
- Sits between the execute/memory stages and reg_file in the RV32I core.

---
 rtl/rf_wb_arbiter.sv | 105 ++++++++++
 1 files changed

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port among writeback requesters,
// with a registered write stage and a pending-write scoreboard for RAW hazard stalls.
module rf_wb_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DATA_W  = 32
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic [NUM_REQ-1:0]         req_valid_in,
  output logic [NUM_REQ-1:0]         req_ready_out,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr_in,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data_in,
  input  logic                       issue_valid_in,
  input  logic [ADDR_W-1:0]          issue_addr_in,
  output logic                       rf_wr_en_out,
  output logic [ADDR_W-1:0]          rf_rd_addr_out,
  output logic [DATA_W-1:0]          rf_rd_data_out,
  output logic [2:0]                 grant_id_out,
  output logic [31:0]                busy_out
);

  logic [2:0]         r_last_grant;
  logic               r_wr_en;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_data;
  logic [2:0]         r_grant_id;
  logic [31:0]        r_busy;

  logic [NUM_REQ-1:0] w_ready;
  logic               w_xfer;
  logic [2:0]         w_grant_idx;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [DATA_W-1:0]  w_sel_data;
  logic [31:0]        w_busy_d;

  // Two passes: indices above the last grant first, then wrap to the rest.
  always_comb begin
    w_ready     = '0;
    w_xfer      = 1'b0;
    w_grant_idx = '0;
    w_sel_addr  = '0;
    w_sel_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!w_xfer && req_valid_in[i] && (i > 32'(r_last_grant))) begin
        w_xfer      = 1'b1;
        w_ready[i]  = 1'b1;
        w_grant_idx = 3'(i);
        w_sel_addr  = req_addr_in[i*ADDR_W +: ADDR_W];
        w_sel_data  = req_data_in[i*DATA_W +: DATA_W];
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!w_xfer && req_valid_in[i] && (i <= 32'(r_last_grant))) begin
        w_xfer      = 1'b1;
        w_ready[i]  = 1'b1;
        w_grant_idx = 3'(i);
        w_sel_addr  = req_addr_in[i*ADDR_W +: ADDR_W];
        w_sel_data  = req_data_in[i*DATA_W +: DATA_W];
      end
    end
  end

  // Clear on commit, then set on issue so a newer writer keeps the bit pending.
  always_comb begin
    w_busy_d = r_busy;
    if (r_wr_en) begin
      w_busy_d[r_addr] = 1'b0;
    end
    if (issue_valid_in) begin
      w_busy_d[issue_addr_in] = 1'b1;
    end
    w_busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_last_grant <= 3'(NUM_REQ - 1);
      r_wr_en      <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
      r_grant_id   <= '0;
      r_busy       <= '0;
    end else begin
      r_busy <= w_busy_d;
      if (w_xfer) begin
        r_wr_en      <= (w_sel_addr != '0);
        r_addr       <= w_sel_addr;
        r_data       <= w_sel_data;
        r_grant_id   <= w_grant_idx;
        r_last_grant <= w_grant_idx;
      end else begin
        r_wr_en <= 1'b0;
      end
    end
  end

  assign req_ready_out  = w_ready;
  assign rf_wr_en_out   = r_wr_en;
  assign rf_rd_addr_out = r_addr;
  assign rf_rd_data_out = r_data;
  assign grant_id_out   = r_grant_id;
  assign busy_out       = r_busy;

endmodule
